// File: rtl/alu_result_buffer.sv
// alu_result_buffer: show-ahead FIFO that holds ALU results (result, overflow
// flag, op code) between the ALU and its consumer. It also keeps overflow statistics.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     producer handshake; in_ready depends only on registered state
//   in_result/in_ov/in_sel  result word, overflow flag, op code (0 add, 1 sub, 2 mul, 3 div)
//   out_valid/out_ready   consumer handshake
//   out_result/out_ov/out_sel  head entry; all zero when the buffer is empty
//   clear_stats           zeroes ov_count/ov_sticky; wins over a same-cycle overflow
//   ov_count              saturating (255) count of accepted overflowed results
//   ov_sticky             set by any accepted overflowed result; held until cleared
//
// Build option: define ALU_RESULT_OV_DROP_EN to count overflowed results without
// storing them.

module alu_result_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic        in_ov,
   input  logic [1:0]  in_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic        out_ov,
   output logic [1:0]  out_sel,
   input  logic        clear_stats,
   output logic [7:0]  ov_count,
   output logic        ov_sticky
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   logic [15:0]   mem_result [DEPTH];
   logic          mem_ov     [DEPTH];
   logic [1:0]    mem_sel    [DEPTH];

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    ov_count_q;
   logic          ov_sticky_q;

   logic push, pop, store;

   assign in_ready  = (count_q < DepthC);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef ALU_RESULT_OV_DROP_EN
   // Overflowed results are accepted (and counted) but never enter storage.
   assign store = push && !in_ov;
`else
   assign store = push;
`endif

   always_comb begin
      count_d = count_q;
      unique case ({store, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; the empty-gating on the outputs hides stale entries.
   always_ff @(posedge clk) begin
      if (rst_n && store) begin
         mem_result[wr_ptr_q] <= in_result;
         mem_ov[wr_ptr_q]     <= in_ov;
         mem_sel[wr_ptr_q]    <= in_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ov_count_q  <= '0;
         ov_sticky_q <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         if (clear_stats) begin
            ov_count_q  <= '0;
            ov_sticky_q <= 1'b0;
         end else if (push && in_ov) begin
            ov_sticky_q <= 1'b1;
            if (ov_count_q != 8'hFF) ov_count_q <= ov_count_q + 8'd1;
         end
      end
   end

   assign out_result = out_valid ? mem_result[rd_ptr_q] : '0;
   assign out_ov     = out_valid ? mem_ov[rd_ptr_q]     : 1'b0;
   assign out_sel    = out_valid ? mem_sel[rd_ptr_q]    : '0;
   assign ov_count   = ov_count_q;
   assign ov_sticky  = ov_sticky_q;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets FIFO entry count; legal values 2, 4, 8, 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 in_valid  input  1  ALU result present this cycle.
REQ-005 in_ready  output  1  buffer accepts a result this cycle.
REQ-006 in_result  input  16  ALU output word.
REQ-007 in_ov  input  1  ALU overflow / divide-by-zero flag.
REQ-008 in_sel  input  2  ALU op code: 0 add, 1 sub, 2 mul, 3 div.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes head entry this cycle.
REQ-011 out_result  output  16  head entry result.
REQ-012 out_ov  output  1  head entry overflow flag.
REQ-013 out_sel  output  2  head entry op code.
REQ-014 clear_stats  input  1  synchronous clear of overflow statistics.
REQ-015 ov_count  output  8  saturating count of overflowed results seen.
REQ-016 ov_sticky  output  1  set on any overflowed result; held until cleared.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready SHALL equal (occupancy < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (occupancy > 0); out_result/out_ov/out_sel SHALL show the head entry (show-ahead) and be 0 when empty.
REQ-020 Latency: a result pushed at edge N SHALL appear on out_* with out_valid=1 after edge N when the buffer was empty before it.
REQ-021 Simultaneous push and pop with occupancy in 1..DEPTH-1 SHALL leave occupancy unchanged and preserve order.
REQ-022 When full, in_ready=0; a push attempt is ignored even if a pop occurs in the same cycle.
REQ-023 When empty, a pop attempt is ignored; a same-cycle push still succeeds.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width is log2(DEPTH)+1.
REQ-025 Each accepted input with in_ov=1 SHALL increment ov_count by 1, saturating at 255, and set ov_sticky.
REQ-026 clear_stats=1 SHALL zero ov_count and ov_sticky at the next edge; if an overflowed push occurs in the same cycle, clear wins and that event is not counted.
REQ-027 clear_stats SHALL NOT affect FIFO contents or pointers.

Reset
REQ-028 With rst_n=0 at an edge: pointers and occupancy 0, in_ready=1, out_valid=0, out_result=0, out_ov=0, out_sel=0, ov_count=0, ov_sticky=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; no push or pop is performed in the reset cycle.

Configuration
REQ-030 Macro ALU_RESULT_OV_DROP_EN: when defined, accepted inputs with in_ov=1 SHALL be counted per REQ-025 but not written to the FIFO (in_ready still governs acceptance); when undefined, all accepted inputs are stored with their in_ov flag.

Verification
REQ-031 Reset, then push sel=0 result 8809 ov=1 (62000+12345) -> next cycle out_valid=1, out_result=8809, out_ov=1, ov_count=1, ov_sticky=1 (macro undefined).
REQ-032 out_ready=0, push 5 results with DEPTH=4 -> in_ready=0 after 4th push, 5th ignored; then drain -> 4 results out in push order, then out_valid=0, out_result=0.
REQ-033 Fill 2 entries, then hold in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays 2, outputs match inputs delayed by 2 pops, pointers wrap correctly.
REQ-034 Push 300 results with in_ov=1 while draining -> ov_count saturates at 255; assert clear_stats with overflowed push in same cycle -> ov_count=0, ov_sticky=0.
REQ-035 ALU_RESULT_OV_DROP_EN defined: push sel=3 result with ov=1 (1234/0) then sel=3 result 5 ov=0 -> only result 5 emerges, ov_count=1.
REQ-036 Assert rst_n=0 with 3 entries stored and in_valid=1 -> next cycle out_valid=0, in_ready=1, ov_count=0.
